// File: rtl/simple_if_to_axil.sv
// -----------------------------------------------------------------------------
// simple_if_to_axil
//
// AXI-Lite initiator bridge. Single-beat write and read requests from the
// simple memory interface are issued as AXI-Lite transactions. The write and
// read engines are independent, and each has exactly one transaction
// outstanding.
//
// Ports
//   clk_i, arst_ni        clock, asynchronous active-low reset
//   axil_req_o            AW/W/AR channels plus b_ready/r_ready (driven)
//   axil_resp_i           aw_ready/w_ready/ar_ready plus B/R channels
//   mem_we_i ..wstrb_i    write request, accepted while mem_wready_o=1
//   mem_wready_o          write engine idle
//   mem_wdone_o           one-cycle write completion pulse
//   mem_wresp_o           BRESP of the last completed write
//   mem_re_i, raddr_i     read request, accepted while mem_rready_o=1
//   mem_rready_o          read engine idle
//   mem_rdone_o           one-cycle read completion pulse
//   mem_rdata_o/rresp_o   RDATA/RRESP of the last completed read
// -----------------------------------------------------------------------------
package dhs_axil_pkg;

    typedef struct packed {
        logic [31:0] aw_addr;
        logic [2:0]  aw_prot;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_valid;
        logic        b_ready;
        logic [31:0] ar_addr;
        logic [2:0]  ar_prot;
        logic        ar_valid;
        logic        r_ready;
    } dhs_axil_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_valid;
    } dhs_axil_resp_t;

endpackage

module simple_if_to_axil
    import dhs_axil_pkg::*;
#(
    parameter type         req_t      = dhs_axil_req_t,
    parameter type         resp_t     = dhs_axil_resp_t,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    output req_t                    axil_req_o,
    input  resp_t                   axil_resp_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
    output logic                    mem_wready_o,
    output logic                    mem_wdone_o,
    output logic [1:0]              mem_wresp_o,
    input  logic                    mem_re_i,
    input  logic [ADDR_WIDTH-1:0]   mem_raddr_i,
    output logic                    mem_rready_o,
    output logic                    mem_rdone_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic [1:0]              mem_rresp_o
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    wstate_e                 r_wstate;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_aw_valid;
    logic                    r_w_valid;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_wdone;
    logic [1:0]              r_wresp;

    rstate_e                 r_rstate;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic                    r_ar_valid;
    logic                    r_rdone;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_aw_hs;
    logic                    w_w_hs;

    assign w_aw_hs = r_aw_valid & axil_resp_i.aw_ready;
    assign w_w_hs  = r_w_valid  & axil_resp_i.w_ready;

    // Write engine
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wstate   <= W_IDLE;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wdone    <= 1'b0;
            r_wresp    <= '0;
        end else begin
            r_wdone <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (mem_we_i) begin
                        r_waddr    <= mem_waddr_i;
                        r_wdata    <= mem_wdata_i;
                        r_wstrb    <= mem_wstrb_i;
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wstate   <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    // Count a handshake happening this cycle as done so both
                    // channels completing together still advance in one step.
                    if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axil_resp_i.b_valid) begin
                        r_wresp  <= axil_resp_i.b_resp;
                        r_wdone  <= 1'b1;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read engine
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rstate   <= R_IDLE;
            r_raddr    <= '0;
            r_ar_valid <= 1'b0;
            r_rdone    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= '0;
        end else begin
            r_rdone <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (mem_re_i) begin
                        r_raddr    <= mem_raddr_i;
                        r_ar_valid <= 1'b1;
                        r_rstate   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (axil_resp_i.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axil_resp_i.r_valid) begin
                        r_rdata  <= axil_resp_i.r_data;
                        r_rresp  <= axil_resp_i.r_resp;
                        r_rdone  <= 1'b1;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axil_req_o          = '0;
        axil_req_o.aw_addr  = r_waddr;
        axil_req_o.aw_prot  = '0;
        axil_req_o.aw_valid = r_aw_valid;
        axil_req_o.w_data   = r_wdata;
        axil_req_o.w_strb   = r_wstrb;
        axil_req_o.w_valid  = r_w_valid;
        axil_req_o.b_ready  = (r_wstate == W_RESP);
        axil_req_o.ar_addr  = r_raddr;
        axil_req_o.ar_prot  = '0;
        axil_req_o.ar_valid = r_ar_valid;
        axil_req_o.r_ready  = (r_rstate == R_DATA);
    end

    assign mem_wready_o = (r_wstate == W_IDLE);
    assign mem_wdone_o  = r_wdone;
    assign mem_wresp_o  = r_wresp;
    assign mem_rready_o = (r_rstate == R_IDLE);
    assign mem_rdone_o  = r_rdone;
    assign mem_rdata_o  = r_rdata;
    assign mem_rresp_o  = r_rresp;

endmodule

// File: tb/tb_simple_if_to_axil.sv
// -----------------------------------------------------------------------------
// tb_simple_if_to_axil
//
// Directed bench for simple_if_to_axil with a configurable-latency AXI-Lite
// slave. Expected AW/W/AR payloads and completion results are queued when a
// request is driven and compared when the matching handshake or done pulse
// is observed.
// -----------------------------------------------------------------------------
module tb_simple_if_to_axil;
    import dhs_axil_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic           arst_ni;
    dhs_axil_req_t  req;
    dhs_axil_resp_t resp;
    logic           mem_we_i;
    logic [31:0]    mem_waddr_i;
    logic [31:0]    mem_wdata_i;
    logic [3:0]     mem_wstrb_i;
    logic           mem_wready_o;
    logic           mem_wdone_o;
    logic [1:0]     mem_wresp_o;
    logic           mem_re_i;
    logic [31:0]    mem_raddr_i;
    logic           mem_rready_o;
    logic           mem_rdone_o;
    logic [31:0]    mem_rdata_o;
    logic [1:0]     mem_rresp_o;

    simple_if_to_axil #(
        .req_t      (dhs_axil_req_t),
        .resp_t     (dhs_axil_resp_t),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .axil_req_o   (req),
        .axil_resp_i  (resp),
        .mem_we_i     (mem_we_i),
        .mem_waddr_i  (mem_waddr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_wstrb_i  (mem_wstrb_i),
        .mem_wready_o (mem_wready_o),
        .mem_wdone_o  (mem_wdone_o),
        .mem_wresp_o  (mem_wresp_o),
        .mem_re_i     (mem_re_i),
        .mem_raddr_i  (mem_raddr_i),
        .mem_rready_o (mem_rready_o),
        .mem_rdone_o  (mem_rdone_o),
        .mem_rdata_o  (mem_rdata_o),
        .mem_rresp_o  (mem_rresp_o)
    );

    // Slave-side drive signals and latency configuration
    logic        s_aw_ready = 1'b0, s_w_ready = 1'b0, s_ar_ready = 1'b0;
    logic        s_b_valid = 1'b0, s_r_valid = 1'b0;
    logic [1:0]  s_b_resp = 2'd0, s_r_resp = 2'd0;
    logic [31:0] s_r_data = 32'd0;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  cfg_b_resp = 2'd0, cfg_r_resp = 2'd0;
    logic [31:0] cfg_r_data = 32'd0;

    always_comb begin
        resp          = '0;
        resp.aw_ready = s_aw_ready;
        resp.w_ready  = s_w_ready;
        resp.b_valid  = s_b_valid;
        resp.b_resp   = s_b_resp;
        resp.ar_ready = s_ar_ready;
        resp.r_valid  = s_r_valid;
        resp.r_data   = s_r_data;
        resp.r_resp   = s_r_resp;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int wdone_cnt = 0, rdone_cnt = 0;
    int last_wdone_cyc = 0, last_rdone_cyc = 0;

    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [1:0]  exp_wresp_q[$];
    logic [33:0] exp_r_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave: ready channels
    initial forever begin
        tick();
        if (req.aw_valid) begin
            for (int k = 0; k < aw_dly && req.aw_valid; k++) tick();
            if (req.aw_valid) begin
                s_aw_ready = 1'b1;
                tick();
                s_aw_ready = 1'b0;
            end
        end
    end

    initial forever begin
        tick();
        if (req.w_valid) begin
            for (int k = 0; k < w_dly && req.w_valid; k++) tick();
            if (req.w_valid) begin
                s_w_ready = 1'b1;
                tick();
                s_w_ready = 1'b0;
            end
        end
    end

    initial forever begin
        tick();
        if (req.ar_valid) begin
            for (int k = 0; k < ar_dly && req.ar_valid; k++) tick();
            if (req.ar_valid) begin
                s_ar_ready = 1'b1;
                tick();
                s_ar_ready = 1'b0;
            end
        end
    end

    // Slave: response channels
    initial forever begin
        tick();
        if (req.b_ready) begin
            for (int k = 0; k < b_dly && req.b_ready; k++) tick();
            if (req.b_ready) begin
                s_b_valid = 1'b1;
                s_b_resp  = cfg_b_resp;
                tick();
                s_b_valid = 1'b0;
            end
        end
    end

    initial forever begin
        tick();
        if (req.r_ready) begin
            for (int k = 0; k < r_dly && req.r_ready; k++) tick();
            if (req.r_ready) begin
                s_r_valid = 1'b1;
                s_r_data  = cfg_r_data;
                s_r_resp  = cfg_r_resp;
                tick();
                s_r_valid = 1'b0;
            end
        end
    end

    // Monitor: handshakes are decided at the next rising edge, so sample mid-cycle
    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (req.aw_valid && resp.aw_ready) begin
                aw_hs++;
                chk("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
                if (exp_aw_q.size() != 0) chk("aw_addr", 64'(req.aw_addr), 64'(exp_aw_q.pop_front()));
                chk("aw_prot", 64'(req.aw_prot), 64'd0);
            end
            if (req.w_valid && resp.w_ready) begin
                w_hs++;
                chk("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) chk("w_payload", 64'({req.w_data, req.w_strb}), 64'(exp_w_q.pop_front()));
            end
            if (req.ar_valid && resp.ar_ready) begin
                ar_hs++;
                chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                if (exp_ar_q.size() != 0) chk("ar_addr", 64'(req.ar_addr), 64'(exp_ar_q.pop_front()));
                chk("ar_prot", 64'(req.ar_prot), 64'd0);
            end
            if (req.b_ready && resp.b_valid) b_hs++;
            if (req.r_ready && resp.r_valid) r_hs++;
            if (mem_wdone_o) begin
                wdone_cnt++;
                last_wdone_cyc = cyc;
                chk("wdone_expected", 64'(exp_wresp_q.size() != 0), 64'd1);
                if (exp_wresp_q.size() != 0) chk("wresp", 64'(mem_wresp_o), 64'(exp_wresp_q.pop_front()));
            end
            if (mem_rdone_o) begin
                rdone_cnt++;
                last_rdone_cyc = cyc;
                chk("rdone_expected", 64'(exp_r_q.size() != 0), 64'd1);
                if (exp_r_q.size() != 0) chk("rdata_rresp", 64'({mem_rdata_o, mem_rresp_o}), 64'(exp_r_q.pop_front()));
            end
        end
    end

    task automatic wait_wready();
        for (int i = 0; i < 200 && !mem_wready_o; i++) tick();
        chk("wready_timeout", 64'(mem_wready_o), 64'd1);
    endtask

    task automatic wait_rready();
        for (int i = 0; i < 200 && !mem_rready_o; i++) tick();
        chk("rready_timeout", 64'(mem_rready_o), 64'd1);
    endtask

    // Drives a write for one cycle; returns one cycle after acceptance.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] br);
        wait_wready();
        mem_we_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d; mem_wstrb_i = s;
        exp_aw_q.push_back(a);
        exp_w_q.push_back({d, s});
        exp_wresp_q.push_back(br);
        tick();
        mem_we_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr);
        wait_rready();
        mem_re_i = 1'b1; mem_raddr_i = a;
        exp_ar_q.push_back(a);
        exp_r_q.push_back({d, rr});
        tick();
        mem_re_i = 1'b0;
    endtask

    task automatic wait_wdone(input int target, input string tag);
        for (int i = 0; i < 200 && wdone_cnt < target; i++) tick();
        chk(tag, 64'(wdone_cnt), 64'(target));
    endtask

    task automatic wait_rdone(input int target, input string tag);
        for (int i = 0; i < 200 && rdone_cnt < target; i++) tick();
        chk(tag, 64'(rdone_cnt), 64'(target));
    endtask

    int base_a, base_b, base_wd, base_rd;

    initial begin
        arst_ni = 1'b0;
        mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        mem_re_i = 1'b0; mem_raddr_i = '0;
        #2;
        // Reset state
        chk("rst_req", 64'(req.aw_valid | req.w_valid | req.b_ready | req.ar_valid | req.r_ready), 64'd0);
        chk("rst_aw_addr", 64'(req.aw_addr), 64'd0);
        chk("rst_w_payload", 64'({req.w_data, req.w_strb}), 64'd0);
        chk("rst_ar_addr", 64'(req.ar_addr), 64'd0);
        chk("rst_readies", 64'({mem_wready_o, mem_rready_o}), 64'b11);
        chk("rst_dones", 64'({mem_wdone_o, mem_rdone_o}), 64'd0);
        chk("rst_results", 64'({mem_wresp_o, mem_rdata_o, mem_rresp_o}), 64'd0);
        tick(); tick();
        arst_ni = 1'b1;
        tick();

        // 1: zero-wait write, exact cycle timing
        cfg_b_resp = 2'd0;
        do_write(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0);
        chk("t1_c1_valids", 64'({req.aw_valid, req.w_valid}), 64'b11);
        chk("t1_c1_aw_addr", 64'(req.aw_addr), 64'h4000_0010);
        chk("t1_c1_w_data", 64'(req.w_data), 64'hDEAD_BEEF);
        chk("t1_c1_w_strb", 64'(req.w_strb), 64'hF);
        chk("t1_c1_wready", 64'(mem_wready_o), 64'd0);
        tick();
        chk("t1_c2_b_ready", 64'(req.b_ready), 64'd1);
        chk("t1_c2_valids", 64'({req.aw_valid, req.w_valid}), 64'd0);
        tick();
        chk("t1_c3_wdone", 64'(mem_wdone_o), 64'd1);
        chk("t1_c3_wresp", 64'(mem_wresp_o), 64'd0);
        chk("t1_c3_wready", 64'(mem_wready_o), 64'd1);
        tick();
        chk("t1_c4_wdone_pulse", 64'(mem_wdone_o), 64'd0);

        // 2a: W accepted 4 cycles before AW
        aw_dly = 4; w_dly = 0; cfg_b_resp = 2'd1;
        base_b = b_hs; base_wd = wdone_cnt;
        do_write(32'h4000_0020, 32'h0BAD_F00D, 4'h3, 2'd1);
        tick(); tick();
        chk("t2a_w_dropped_aw_held", 64'({req.aw_valid, req.w_valid}), 64'b10);
        wait_wdone(base_wd + 1, "t2a_done");
        tick(); tick(); tick();
        chk("t2a_one_b", 64'(b_hs), 64'(base_b + 1));
        chk("t2a_one_done", 64'(wdone_cnt), 64'(base_wd + 1));

        // 2b: AW accepted 4 cycles before W
        aw_dly = 0; w_dly = 4; cfg_b_resp = 2'd3;
        base_b = b_hs; base_wd = wdone_cnt;
        do_write(32'h4000_0024, 32'h1357_9BDF, 4'hC, 2'd3);
        tick(); tick();
        chk("t2b_aw_dropped_w_held", 64'({req.aw_valid, req.w_valid}), 64'b01);
        wait_wdone(base_wd + 1, "t2b_done");
        tick(); tick(); tick();
        chk("t2b_one_b", 64'(b_hs), 64'(base_b + 1));
        chk("t2b_one_done", 64'(wdone_cnt), 64'(base_wd + 1));
        chk("t2b_wresp_held", 64'(mem_wresp_o), 64'd3);
        w_dly = 0;

        // 3: read with 5-cycle R delay and SLVERR
        r_dly = 5; cfg_r_data = 32'h1234_5678; cfg_r_resp = 2'd2;
        base_rd = rdone_cnt;
        do_read(32'h4000_0004, 32'h1234_5678, 2'd2);
        chk("t3_ar_valid", 64'(req.ar_valid), 64'd1);
        chk("t3_ar_addr", 64'(req.ar_addr), 64'h4000_0004);
        wait_rdone(base_rd + 1, "t3_done");
        tick(); tick(); tick();
        chk("t3_one_rdone", 64'(rdone_cnt), 64'(base_rd + 1));
        chk("t3_rdata_held", 64'(mem_rdata_o), 64'h1234_5678);
        chk("t3_rresp_held", 64'(mem_rresp_o), 64'd2);

        // 4: simultaneous write and read, B three cycles later than R
        r_dly = 0; b_dly = 3; cfg_b_resp = 2'd2; cfg_r_data = 32'hCAFE_0001; cfg_r_resp = 2'd0;
        base_wd = wdone_cnt; base_rd = rdone_cnt;
        wait_wready(); wait_rready();
        mem_we_i = 1'b1; mem_waddr_i = 32'h4000_0100; mem_wdata_i = 32'hA5A5_0F0F; mem_wstrb_i = 4'h5;
        mem_re_i = 1'b1; mem_raddr_i = 32'h4000_0200;
        exp_aw_q.push_back(32'h4000_0100); exp_w_q.push_back({32'hA5A5_0F0F, 4'h5});
        exp_wresp_q.push_back(2'd2);
        exp_ar_q.push_back(32'h4000_0200); exp_r_q.push_back({32'hCAFE_0001, 2'd0});
        tick();
        mem_we_i = 1'b0; mem_re_i = 1'b0;
        chk("t4_both_accepted", 64'({req.aw_valid, req.w_valid, req.ar_valid}), 64'b111);
        wait_wdone(base_wd + 1, "t4_wdone");
        wait_rdone(base_rd + 1, "t4_rdone");
        chk("t4_r_before_w", 64'(last_rdone_cyc < last_wdone_cyc), 64'd1);
        chk("t4_gap", 64'(last_wdone_cyc - last_rdone_cyc), 64'd3);

        // 5: request while in W_RESP is ignored; request on the done cycle is taken
        b_dly = 5; cfg_b_resp = 2'd1;
        base_a = aw_hs; base_wd = wdone_cnt;
        do_write(32'h4000_0300, 32'h0000_1111, 4'hF, 2'd1);
        for (int i = 0; i < 50 && !req.b_ready; i++) tick();
        chk("t5_in_resp", 64'(req.b_ready), 64'd1);
        chk("t5_wready_low", 64'(mem_wready_o), 64'd0);
        mem_we_i = 1'b1; mem_waddr_i = 32'hBAD0_0000; mem_wdata_i = 32'hFFFF_FFFF;
        tick();
        mem_we_i = 1'b0;
        for (int i = 0; i < 50 && !mem_wdone_o; i++) tick();
        chk("t5_done_seen", 64'(mem_wdone_o), 64'd1);
        chk("t5_ready_on_done", 64'(mem_wready_o), 64'd1);
        b_dly = 0; cfg_b_resp = 2'd0;
        do_write(32'h4000_0304, 32'h0000_2222, 4'h1, 2'd0);
        chk("t5_b2b_aw_valid", 64'(req.aw_valid), 64'd1);
        chk("t5_b2b_aw_addr", 64'(req.aw_addr), 64'h4000_0304);
        wait_wdone(base_wd + 2, "t5_done");
        chk("t5_aw_count", 64'(aw_hs), 64'(base_a + 2));

        // 6: reset while AW is pending
        aw_dly = 20; w_dly = 0; cfg_b_resp = 2'd0;
        base_wd = wdone_cnt;
        do_write(32'h4000_0400, 32'h7777_8888, 4'hF, 2'd0);
        tick();
        chk("t6_aw_pending", 64'(req.aw_valid), 64'd1);
        arst_ni = 1'b0;
        #1;
        chk("t6_valids_dropped", 64'({req.aw_valid, req.w_valid, req.ar_valid}), 64'd0);
        chk("t6_readies_dropped", 64'({req.b_ready, req.r_ready}), 64'd0);
        chk("t6_idle", 64'({mem_wready_o, mem_rready_o}), 64'b11);
        tick(); tick();
        exp_aw_q.delete(); exp_w_q.delete(); exp_wresp_q.delete();
        arst_ni = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_done", 64'(wdone_cnt), 64'(base_wd));
        aw_dly = 0;
        do_write(32'h4000_0404, 32'h55AA_55AA, 4'hF, 2'd0);
        wait_wdone(base_wd + 1, "t6_recover");
        tick(); tick();
        chk("t6_queues_empty", 64'(exp_aw_q.size() + exp_w_q.size() + exp_wresp_q.size() + exp_ar_q.size() + exp_r_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
